icache_miss_controller: RTL and testbench

Sequencer for L1 instruction-cache miss handling. It captures a miss reported by the fetch unit, stalls fetch, and issues a line request to the next memory level. It writes the returned line into the L1I cache-update port, then redirects fetch to the missed address. It also owns the cache's natural-write port, buffering natural writes so they never collide with a refill.

---
 rtl/icache_ctrl_pkg.sv | 47 ++++
 rtl/icache_write_slot.sv | 80 ++++++++
 rtl/icache_miss_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_icache_miss_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_ctrl_pkg
// Shared definitions for the L1 instruction-cache miss controller:
//   - miss_state_e : 3-bit FSM state encoding (IDLE, REQUEST, WAIT, FILL, REPLAY)
//   - DEF_*        : default width / limit constants used as parameter defaults
//   - line_align() : clears the line-offset bits of an address
// No ports (package).
// -----------------------------------------------------------------------------
package icache_ctrl_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH    = 32'd64;
  localparam int unsigned DEF_LINE_WIDTH       = 32'd512;
  localparam int unsigned DEF_OFFSET_WIDTH     = 32'd6;
  localparam int unsigned DEF_PID_SIZE         = 32'd32;
  localparam int unsigned DEF_TID_SIZE         = 32'd64;
  localparam int unsigned DEF_INST_CNT_WIDTH   = 32'd64;
  localparam int unsigned DEF_TIMEOUT_CYCLES   = 32'd1023;

  // Widest address the align helper handles; callers zero-extend into it.
  localparam int unsigned MAX_ADDRESS_WIDTH    = 32'd128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_WAIT    = 3'd2,
    ST_FILL    = 3'd3,
    ST_REPLAY  = 3'd4
  } miss_state_e;

  // Zero the low offset_bits bits so the address points at the start of its line.
  function automatic logic [MAX_ADDRESS_WIDTH-1:0] line_align(
    input logic [MAX_ADDRESS_WIDTH-1:0] addr,
    input int unsigned                  offset_bits
  );
    logic [MAX_ADDRESS_WIDTH-1:0] res;
    res = addr;
    for (int unsigned i = 0; i < MAX_ADDRESS_WIDTH; i++) begin
      if (i < offset_bits) begin
        res[i] = 1'b0;
      end else begin
        res[i] = addr[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_write_slot.sv
// -----------------------------------------------------------------------------
// icache_write_slot
// One-entry buffer in front of the L1I natural-write port. A request is
// accepted when the slot is empty or is draining this cycle; the slot drains
// whenever it holds data and the refill path is not using the port.
// Ports:
//   clock_i, reset_i           clock, synchronous active-high reset
//   fill_busy_i                refill owns the L1I write port this cycle
//   req_i, ack_o               incoming write request / accepted this cycle
//   addr_i/line_i/pid_i/tid_i  incoming write data
//   write_en_o                 write to L1I this cycle
//   addr_o/line_o/pid_o/tid_o  buffered write data
// -----------------------------------------------------------------------------
module icache_write_slot #(
  parameter int unsigned ADDR_W = 32'd64,
  parameter int unsigned LINE_W = 32'd512,
  parameter int unsigned PID_W  = 32'd32,
  parameter int unsigned TID_W  = 32'd64
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              fill_busy_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic [PID_W-1:0]  pid_i,
  input  logic [TID_W-1:0]  tid_i,
  output logic              ack_o,
  output logic              write_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LINE_W-1:0] line_o,
  output logic [PID_W-1:0]  pid_o,
  output logic [TID_W-1:0]  tid_o
);

  logic              valid_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] line_r;
  logic [PID_W-1:0]  pid_r;
  logic [TID_W-1:0]  tid_r;
  logic              drain_s;
  logic              accept_s;

  // Drain/accept decisions; accepting while draining keeps the slot full.
  always_comb begin
    drain_s  = valid_r && !fill_busy_i;
    accept_s = req_i && (!valid_r || drain_s);
  end

  // Slot occupancy and payload registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_r <= 1'b0;
      addr_r  <= '0;
      line_r  <= '0;
      pid_r   <= '0;
      tid_r   <= '0;
    end else begin
      if (accept_s) begin
        valid_r <= 1'b1;
        addr_r  <= addr_i;
        line_r  <= line_i;
        pid_r   <= pid_i;
        tid_r   <= tid_i;
      end else if (drain_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign ack_o      = accept_s;
  assign write_en_o = drain_s;
  assign addr_o     = addr_r;
  assign line_o     = line_r;
  assign pid_o      = pid_r;
  assign tid_o      = tid_r;

endmodule

// File: rtl/icache_miss_controller.sv
// -----------------------------------------------------------------------------
// icache_miss_controller
// Handles an L1I miss: latches the miss context, stalls fetch, issues a
// line-aligned request, writes the returned line into the cache and then
// redirects fetch to the original (unaligned) address. Also fronts the cache
// natural-write port through a one-entry slot that yields to refills.
//
// Optional feature: define MISS_TIMEOUT_EN to abandon a miss with missError_o
// after timeoutCycles cycles in WAIT without a response.
//
// Ports:
//   clock_i, reset_i                     clock, synchronous active-high reset
//   cacheMiss_i + missed*_i              miss pulse and context from fetch
//   fetchStall_o                         stall fetch (miss pending or arriving)
//   fetchRedirect_o/Address_o            one-cycle redirect after refill
//   memReq*_o, memReqReady_i             line request to next level
//   memResp*_i                           line response / error
//   natWrite*_i, natWriteAck_o           natural write request interface
//   cacheUpdate*_o                       refill write to L1I
//   naturalWrite*_o, natural*_o          natural write to L1I
//   missError_o                          one-cycle error pulse
// -----------------------------------------------------------------------------
module icache_miss_controller
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned addressWidth            = DEF_ADDRESS_WIDTH,
  parameter int unsigned cacheLineWidth          = DEF_LINE_WIDTH,
  parameter int unsigned offsetWidth             = DEF_OFFSET_WIDTH,
  parameter int unsigned PidSize                 = DEF_PID_SIZE,
  parameter int unsigned TidSize                 = DEF_TID_SIZE,
  parameter int unsigned instructionCounterWidth = DEF_INST_CNT_WIDTH,
  parameter int unsigned timeoutCycles           = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               cacheMiss_i,
  input  logic [addressWidth-1:0]            missedAddress_i,
  input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
  input  logic [PidSize-1:0]                 missedPid_i,
  input  logic [TidSize-1:0]                 missedTid_i,
  output logic                               fetchStall_o,
  output logic                               fetchRedirect_o,
  output logic [addressWidth-1:0]            fetchRedirectAddress_o,
  output logic                               memReqValid_o,
  input  logic                               memReqReady_i,
  output logic [addressWidth-1:0]            memReqAddress_o,
  input  logic                               memRespValid_i,
  input  logic                               memRespError_i,
  input  logic [cacheLineWidth-1:0]          memRespLine_i,
  input  logic                               natWriteReq_i,
  output logic                               natWriteAck_o,
  input  logic [addressWidth-1:0]            natWriteAddress_i,
  input  logic [cacheLineWidth-1:0]          natWriteLine_i,
  input  logic [PidSize-1:0]                 natWritePid_i,
  input  logic [TidSize-1:0]                 natWriteTid_i,
  output logic                               cacheUpdate_o,
  output logic [addressWidth-1:0]            cacheUpdateAddress_o,
  output logic [cacheLineWidth-1:0]          cacheUpdateLine_o,
  output logic [PidSize-1:0]                 cacheUpdatePid_o,
  output logic [TidSize-1:0]                 cacheUpdateTid_o,
  output logic [instructionCounterWidth-1:0] cacheUpdateMajId_o,
  output logic                               naturalWriteEn_o,
  output logic [addressWidth-1:0]            naturalWriteAddress_o,
  output logic [cacheLineWidth-1:0]          naturalWriteLine_o,
  output logic [PidSize-1:0]                 naturalPid_o,
  output logic [TidSize-1:0]                 naturalTid_o,
  output logic                               missError_o
);

  miss_state_e                        state_r;
  miss_state_e                        state_s;
  logic [addressWidth-1:0]            addr_r;
  logic [instructionCounterWidth-1:0] maj_r;
  logic [PidSize-1:0]                 pid_r;
  logic [TidSize-1:0]                 tid_r;
  logic [cacheLineWidth-1:0]          line_r;
  logic                               miss_err_r;
  logic                               capture_s;
  logic                               line_load_s;
  logic                               miss_err_s;
  logic                               timeout_hit_s;
  logic [addressWidth-1:0]            aligned_addr_s;

  assign aligned_addr_s =
    addressWidth'(line_align(MAX_ADDRESS_WIDTH'(addr_r), offsetWidth));

`ifdef MISS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(timeoutCycles + 32'd1);
  logic [CNT_W-1:0] wait_cnt_r;

  // WAIT-cycle counter: zero on entry to WAIT, counts every cycle spent there.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // The limit is reached at the edge that closes the timeoutCycles-th WAIT cycle.
  assign timeout_hit_s = (state_r == ST_WAIT) &&
                         (wait_cnt_r == CNT_W'(timeoutCycles - 32'd1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state logic and capture strobes.
  always_comb begin
    state_s     = state_r;
    capture_s   = 1'b0;
    line_load_s = 1'b0;
    miss_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cacheMiss_i) begin
          state_s   = ST_REQUEST;
          capture_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (memReqReady_i) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQUEST;
        end
      end
      ST_WAIT: begin
        if (memRespValid_i && !memRespError_i) begin
          state_s     = ST_FILL;
          line_load_s = 1'b1;
        end else if (memRespValid_i || timeout_hit_s) begin
          state_s    = ST_IDLE;
          miss_err_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_FILL:   state_s = ST_REPLAY;
      ST_REPLAY: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, miss context, returned line and error pulse registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      maj_r      <= '0;
      pid_r      <= '0;
      tid_r      <= '0;
      line_r     <= '0;
      miss_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      miss_err_r <= miss_err_s;
      if (capture_s) begin
        addr_r <= missedAddress_i;
        maj_r  <= missedInstMajorId_i;
        pid_r  <= missedPid_i;
        tid_r  <= missedTid_i;
      end else begin
        addr_r <= addr_r;
        maj_r  <= maj_r;
        pid_r  <= pid_r;
        tid_r  <= tid_r;
      end
      if (line_load_s) begin
        line_r <= memRespLine_i;
      end else begin
        line_r <= line_r;
      end
    end
  end

  // State-decoded outputs; data buses read zero whenever their strobe is low.
  always_comb begin
    memReqValid_o          = 1'b0;
    memReqAddress_o        = '0;
    cacheUpdate_o          = 1'b0;
    cacheUpdateAddress_o   = '0;
    cacheUpdateLine_o      = '0;
    cacheUpdatePid_o       = '0;
    cacheUpdateTid_o       = '0;
    cacheUpdateMajId_o     = '0;
    fetchRedirect_o        = 1'b0;
    fetchRedirectAddress_o = '0;
    case (state_r)
      ST_REQUEST: begin
        memReqValid_o   = 1'b1;
        memReqAddress_o = aligned_addr_s;
      end
      ST_FILL: begin
        cacheUpdate_o        = 1'b1;
        cacheUpdateAddress_o = aligned_addr_s;
        cacheUpdateLine_o    = line_r;
        cacheUpdatePid_o     = pid_r;
        cacheUpdateTid_o     = tid_r;
        cacheUpdateMajId_o   = maj_r;
      end
      ST_REPLAY: begin
        fetchRedirect_o        = 1'b1;
        fetchRedirectAddress_o = addr_r;
      end
      default: begin
        memReqValid_o = 1'b0;
      end
    endcase
  end

  assign fetchStall_o = cacheMiss_i || (state_r != ST_IDLE);
  assign missError_o  = miss_err_r;

  icache_write_slot #(
    .ADDR_W (addressWidth),
    .LINE_W (cacheLineWidth),
    .PID_W  (PidSize),
    .TID_W  (TidSize)
  ) u_write_slot (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .fill_busy_i (state_r == ST_FILL),
    .req_i       (natWriteReq_i),
    .addr_i      (natWriteAddress_i),
    .line_i      (natWriteLine_i),
    .pid_i       (natWritePid_i),
    .tid_i       (natWriteTid_i),
    .ack_o       (natWriteAck_o),
    .write_en_o  (naturalWriteEn_o),
    .addr_o      (naturalWriteAddress_o),
    .line_o      (naturalWriteLine_o),
    .pid_o       (naturalPid_o),
    .tid_o       (naturalTid_o)
  );

endmodule

// File: tb/tb_icache_miss_controller.sv
// -----------------------------------------------------------------------------
// tb_icache_miss_controller
// Cycle-table test of the refill sequence plus hand-written sequences for
// backpressure, write-port collision, error, timeout (MISS_TIMEOUT_EN),
// and reset mid-miss. Refills, redirects and natural writes are checked
// against queues of expected transactions.
// -----------------------------------------------------------------------------
module tb_icache_miss_controller;

  localparam int AW = 64;
  localparam int LW = 512;
  localparam int PW = 32;
  localparam int TW = 64;
  localparam int IW = 64;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          cacheMiss_i;
  logic [AW-1:0] missedAddress_i;
  logic [IW-1:0] missedInstMajorId_i;
  logic [PW-1:0] missedPid_i;
  logic [TW-1:0] missedTid_i;
  logic          fetchStall_o, fetchRedirect_o;
  logic [AW-1:0] fetchRedirectAddress_o;
  logic          memReqValid_o, memReqReady_i;
  logic [AW-1:0] memReqAddress_o;
  logic          memRespValid_i, memRespError_i;
  logic [LW-1:0] memRespLine_i;
  logic          natWriteReq_i, natWriteAck_o;
  logic [AW-1:0] natWriteAddress_i;
  logic [LW-1:0] natWriteLine_i;
  logic [PW-1:0] natWritePid_i;
  logic [TW-1:0] natWriteTid_i;
  logic          cacheUpdate_o;
  logic [AW-1:0] cacheUpdateAddress_o;
  logic [LW-1:0] cacheUpdateLine_o;
  logic [PW-1:0] cacheUpdatePid_o;
  logic [TW-1:0] cacheUpdateTid_o;
  logic [IW-1:0] cacheUpdateMajId_o;
  logic          naturalWriteEn_o;
  logic [AW-1:0] naturalWriteAddress_o;
  logic [LW-1:0] naturalWriteLine_o;
  logic [PW-1:0] naturalPid_o;
  logic [TW-1:0] naturalTid_o;
  logic          missError_o;

  always #5 clock_i = ~clock_i;

  icache_miss_controller #(
    .addressWidth(AW), .cacheLineWidth(LW), .offsetWidth(6), .PidSize(PW),
    .TidSize(TW), .instructionCounterWidth(IW), .timeoutCycles(8)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .cacheMiss_i(cacheMiss_i),
    .missedAddress_i(missedAddress_i), .missedInstMajorId_i(missedInstMajorId_i),
    .missedPid_i(missedPid_i), .missedTid_i(missedTid_i),
    .fetchStall_o(fetchStall_o), .fetchRedirect_o(fetchRedirect_o),
    .fetchRedirectAddress_o(fetchRedirectAddress_o),
    .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
    .memReqAddress_o(memReqAddress_o), .memRespValid_i(memRespValid_i),
    .memRespError_i(memRespError_i), .memRespLine_i(memRespLine_i),
    .natWriteReq_i(natWriteReq_i), .natWriteAck_o(natWriteAck_o),
    .natWriteAddress_i(natWriteAddress_i), .natWriteLine_i(natWriteLine_i),
    .natWritePid_i(natWritePid_i), .natWriteTid_i(natWriteTid_i),
    .cacheUpdate_o(cacheUpdate_o), .cacheUpdateAddress_o(cacheUpdateAddress_o),
    .cacheUpdateLine_o(cacheUpdateLine_o), .cacheUpdatePid_o(cacheUpdatePid_o),
    .cacheUpdateTid_o(cacheUpdateTid_o), .cacheUpdateMajId_o(cacheUpdateMajId_o),
    .naturalWriteEn_o(naturalWriteEn_o), .naturalWriteAddress_o(naturalWriteAddress_o),
    .naturalWriteLine_o(naturalWriteLine_o), .naturalPid_o(naturalPid_o),
    .naturalTid_o(naturalTid_o), .missError_o(missError_o)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
    logic [PW-1:0] pid;
    logic [TW-1:0] tid;
    logic [IW-1:0] maj;
  } xact_t;

  xact_t         upd_q[$];
  logic [AW-1:0] redir_q[$];
  xact_t         nat_q[$];
  xact_t         mon_x;
  logic [AW-1:0] mon_a;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Push the refill and redirect that the current miss context should produce.
  task automatic expect_refill(input logic [LW-1:0] line);
    xact_t x;
    x.addr = {missedAddress_i[AW-1:6], 6'b0};
    x.line = line;
    x.pid  = missedPid_i;
    x.tid  = missedTid_i;
    x.maj  = missedInstMajorId_i;
    upd_q.push_back(x);
    redir_q.push_back(missedAddress_i);
  endtask

  // Monitor: pop and compare every refill, redirect and natural write; record accepted writes.
  always @(negedge clock_i) begin
    if (cacheUpdate_o || naturalWriteEn_o)
      chk("port_collision", LW'(cacheUpdate_o && naturalWriteEn_o), LW'(1'b0));
    if (cacheUpdate_o) begin
      if (upd_q.size() == 0) begin
        chk("unexpected_update", LW'(cacheUpdate_o), LW'(1'b0));
      end else begin
        mon_x = upd_q.pop_front();
        chk("upd_addr", LW'(cacheUpdateAddress_o), LW'(mon_x.addr));
        chk("upd_line", cacheUpdateLine_o, mon_x.line);
        chk("upd_pid", LW'(cacheUpdatePid_o), LW'(mon_x.pid));
        chk("upd_tid", LW'(cacheUpdateTid_o), LW'(mon_x.tid));
        chk("upd_maj", LW'(cacheUpdateMajId_o), LW'(mon_x.maj));
      end
    end
    if (fetchRedirect_o) begin
      if (redir_q.size() == 0) begin
        chk("unexpected_redirect", LW'(fetchRedirect_o), LW'(1'b0));
      end else begin
        mon_a = redir_q.pop_front();
        chk("redir_addr", LW'(fetchRedirectAddress_o), LW'(mon_a));
      end
    end
    if (naturalWriteEn_o) begin
      if (nat_q.size() == 0) begin
        chk("unexpected_nat_write", LW'(naturalWriteEn_o), LW'(1'b0));
      end else begin
        mon_x = nat_q.pop_front();
        chk("nat_addr", LW'(naturalWriteAddress_o), LW'(mon_x.addr));
        chk("nat_line", naturalWriteLine_o, mon_x.line);
        chk("nat_pid", LW'(naturalPid_o), LW'(mon_x.pid));
        chk("nat_tid", LW'(naturalTid_o), LW'(mon_x.tid));
      end
    end
    if (natWriteReq_i && natWriteAck_o) begin
      mon_x.addr = natWriteAddress_i;
      mon_x.line = natWriteLine_i;
      mon_x.pid  = natWritePid_i;
      mon_x.tid  = natWriteTid_i;
      mon_x.maj  = '0;
      nat_q.push_back(mon_x);
    end
  end

  typedef struct {
    logic miss, ready, rvalid, fill;
    logic stall, reqv, upd, redir, err;
  } vec_t;

  vec_t tbl[8];

  task automatic set_nat(input logic req, input logic [AW-1:0] a, input logic [7:0] b);
    natWriteReq_i     = req;
    natWriteAddress_i = a;
    natWriteLine_i    = {64{b}};
    natWritePid_i     = {24'h0, b};
    natWriteTid_i     = {56'h0, ~b};
  endtask

  initial begin
    reset_i = 1'b1; cacheMiss_i = 1'b0; memReqReady_i = 1'b0;
    memRespValid_i = 1'b0; memRespError_i = 1'b0; memRespLine_i = '0;
    missedAddress_i = '0; missedInstMajorId_i = '0; missedPid_i = '0; missedTid_i = '0;
    set_nat(1'b0, '0, 8'h00);

    // ---------------- reset state ----------------
    tick(); tick();
    @(negedge clock_i);
    chk("rst_stall", LW'(fetchStall_o), LW'(1'b0));
    chk("rst_reqv", LW'(memReqValid_o), LW'(1'b0));
    chk("rst_upd", LW'(cacheUpdate_o), LW'(1'b0));
    chk("rst_redir", LW'(fetchRedirect_o), LW'(1'b0));
    chk("rst_err", LW'(missError_o), LW'(1'b0));
    chk("rst_nat_en", LW'(naturalWriteEn_o), LW'(1'b0));
    chk("rst_req_addr", LW'(memReqAddress_o), LW'(0));
    tick();
    reset_i = 1'b0;

    // ---------------- basic refill (table) ----------------
    //            miss  rdy   rv    fill  stall reqv  upd   redir err
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    missedAddress_i = 64'h1044; missedPid_i = 32'h11; missedTid_i = 64'h22;
    missedInstMajorId_i = 64'h33;
    memRespLine_i = {64{8'hA5}};
    for (int i = 0; i < 8; i++) begin
      cacheMiss_i    = tbl[i].miss;
      memReqReady_i  = tbl[i].ready;
      memRespValid_i = tbl[i].rvalid;
      if (tbl[i].fill) begin
        missedAddress_i = 64'h1044; missedPid_i = 32'h11; missedTid_i = 64'h22;
        missedInstMajorId_i = 64'h33;
        expect_refill({64{8'hA5}});
      end
      if (i == 2) begin
        // A second miss while busy carries a different context that must be ignored.
        missedAddress_i = 64'hDEAD_0000; missedPid_i = 32'h99;
      end
      @(negedge clock_i);
      chk($sformatf("tbl%0d_stall", i), LW'(fetchStall_o), LW'(tbl[i].stall));
      chk($sformatf("tbl%0d_reqv", i), LW'(memReqValid_o), LW'(tbl[i].reqv));
      chk($sformatf("tbl%0d_upd", i), LW'(cacheUpdate_o), LW'(tbl[i].upd));
      chk($sformatf("tbl%0d_redir", i), LW'(fetchRedirect_o), LW'(tbl[i].redir));
      chk($sformatf("tbl%0d_err", i), LW'(missError_o), LW'(tbl[i].err));
      if (tbl[i].reqv) chk($sformatf("tbl%0d_req_addr", i), LW'(memReqAddress_o), LW'(64'h1040));
      tick();
    end
    cacheMiss_i = 1'b0; memReqReady_i = 1'b0; memRespValid_i = 1'b0;

    // ---------------- backpressure ----------------
    missedAddress_i = 64'h2_0088; missedPid_i = 32'h5; missedTid_i = 64'h6;
    missedInstMajorId_i = 64'h7;
    cacheMiss_i = 1'b1;
    tick();
    cacheMiss_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      memReqReady_i = (i == 5);
      @(negedge clock_i);
      chk($sformatf("bp%0d_reqv", i), LW'(memReqValid_o), LW'(1'b1));
      chk($sformatf("bp%0d_addr", i), LW'(memReqAddress_o), LW'(64'h2_0080));
      tick();
    end
    memReqReady_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock_i);
      chk($sformatf("bp_wait%0d_reqv", i), LW'(memReqValid_o), LW'(1'b0));
      tick();
    end
    memRespValid_i = 1'b1; memRespLine_i = {8{64'h0123_4567_89AB_CDEF}};
    expect_refill({8{64'h0123_4567_89AB_CDEF}});
    tick();
    memRespValid_i = 1'b0;
    tick(); tick();
    @(negedge clock_i);
    chk("bp_stall_done", LW'(fetchStall_o), LW'(1'b0));

    // ---------------- write-port collision ----------------
    missedAddress_i = 64'h3_0104; missedPid_i = 32'hA; missedTid_i = 64'hB;
    missedInstMajorId_i = 64'hC;
    cacheMiss_i = 1'b1; tick(); cacheMiss_i = 1'b0;
    memReqReady_i = 1'b1; tick(); memReqReady_i = 1'b0;
    memRespValid_i = 1'b1; memRespLine_i = {64{8'h3C}};
    expect_refill({64{8'h3C}});
    set_nat(1'b1, 64'h5000, 8'h51);
    @(negedge clock_i);
    chk("col_ack_empty", LW'(natWriteAck_o), LW'(1'b1));
    tick();
    memRespValid_i = 1'b0;
    set_nat(1'b1, 64'h6000, 8'h62);
    @(negedge clock_i);
    chk("col_fill_upd", LW'(cacheUpdate_o), LW'(1'b1));
    chk("col_fill_nat_en", LW'(naturalWriteEn_o), LW'(1'b0));
    chk("col_ack_blocked", LW'(natWriteAck_o), LW'(1'b0));
    tick();
    set_nat(1'b0, '0, 8'h00);
    @(negedge clock_i);
    chk("col_replay_nat_en", LW'(naturalWriteEn_o), LW'(1'b1));
    tick();
    @(negedge clock_i);
    chk("col_after_nat_en", LW'(naturalWriteEn_o), LW'(1'b0));

    // ---------------- back-to-back natural writes in IDLE ----------------
    set_nat(1'b1, 64'h7000, 8'h73);
    @(negedge clock_i);
    chk("nat0_ack", LW'(natWriteAck_o), LW'(1'b1));
    tick();
    set_nat(1'b1, 64'h8000, 8'h84);
    @(negedge clock_i);
    chk("nat1_ack_drain", LW'(natWriteAck_o), LW'(1'b1));
    chk("nat1_en", LW'(naturalWriteEn_o), LW'(1'b1));
    tick();
    set_nat(1'b0, '0, 8'h00);
    @(negedge clock_i);
    chk("nat2_en", LW'(naturalWriteEn_o), LW'(1'b1));
    tick();
    @(negedge clock_i);
    chk("nat3_en", LW'(naturalWriteEn_o), LW'(1'b0));

    // ---------------- error response ----------------
    missedAddress_i = 64'h4_0010;
    cacheMiss_i = 1'b1; tick(); cacheMiss_i = 1'b0;
    memReqReady_i = 1'b1; tick(); memReqReady_i = 1'b0;
    memRespValid_i = 1'b1; memRespError_i = 1'b1;
    @(negedge clock_i);
    chk("err_m_pulse", LW'(missError_o), LW'(1'b0));
    tick();
    memRespValid_i = 1'b0; memRespError_i = 1'b0;
    @(negedge clock_i);
    chk("err_pulse", LW'(missError_o), LW'(1'b1));
    chk("err_idle_stall", LW'(fetchStall_o), LW'(1'b0));
    chk("err_no_upd", LW'(cacheUpdate_o), LW'(1'b0));
    tick();
    @(negedge clock_i);
    chk("err_pulse_end", LW'(missError_o), LW'(1'b0));
    chk("err_no_redir", LW'(fetchRedirect_o), LW'(1'b0));
    chk("err_no_req", LW'(memReqValid_o), LW'(1'b0));
    tick();

`ifdef MISS_TIMEOUT_EN
    // ---------------- timeout (limit 8) ----------------
    missedAddress_i = 64'h9_0000;
    cacheMiss_i = 1'b1; tick(); cacheMiss_i = 1'b0;
    memReqReady_i = 1'b1; tick(); memReqReady_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock_i);
      chk($sformatf("to_wait%0d_err", i), LW'(missError_o), LW'(1'b0));
      chk($sformatf("to_wait%0d_stall", i), LW'(fetchStall_o), LW'(1'b1));
      tick();
    end
    @(negedge clock_i);
    chk("to_err", LW'(missError_o), LW'(1'b1));
    chk("to_idle", LW'(fetchStall_o), LW'(1'b0));
    tick(); tick();
    memRespValid_i = 1'b1; memRespLine_i = {64{8'hEE}};
    tick();
    memRespValid_i = 1'b0;
    @(negedge clock_i);
    chk("to_late_no_upd", LW'(cacheUpdate_o), LW'(1'b0));
    tick();
`endif

    // ---------------- reset mid-miss ----------------
    missedAddress_i = 64'hA_0044;
    cacheMiss_i = 1'b1; tick(); cacheMiss_i = 1'b0;
    memReqReady_i = 1'b1; tick(); memReqReady_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    memRespValid_i = 1'b1; memRespLine_i = {64{8'h77}};
    @(negedge clock_i);
    chk("rm_stall", LW'(fetchStall_o), LW'(1'b0));
    chk("rm_reqv", LW'(memReqValid_o), LW'(1'b0));
    chk("rm_req_addr", LW'(memReqAddress_o), LW'(0));
    chk("rm_upd", LW'(cacheUpdate_o), LW'(1'b0));
    chk("rm_upd_line", cacheUpdateLine_o, LW'(0));
    chk("rm_redir_addr", LW'(fetchRedirectAddress_o), LW'(0));
    chk("rm_nat_line", naturalWriteLine_o, LW'(0));
    chk("rm_err", LW'(missError_o), LW'(1'b0));
    tick();
    memRespValid_i = 1'b0;
    @(negedge clock_i);
    chk("rm_late_no_upd", LW'(cacheUpdate_o), LW'(1'b0));
    tick();
    @(negedge clock_i);
    chk("rm_late_no_redir", LW'(fetchRedirect_o), LW'(1'b0));
    tick();

    // Everything expected must have been produced.
    chk("upd_q_drained", LW'(upd_q.size()), LW'(0));
    chk("redir_q_drained", LW'(redir_q.size()), LW'(0));
    chk("nat_q_drained", LW'(nat_q.size()), LW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
